// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path (and the planned transmit side).
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_MID = 4'd7;
    localparam logic [3:0] SAMPLE_END = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Clock cycles per oversample tick (integer truncation).
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

    // True when the received parity bit matches the configured mode.
    function automatic logic parity_ok(input logic data_xor, input logic pbit, input int mode);
        logic x;
        logic ok;
        x = data_xor ^ pbit;
        case (mode)
            PARITY_ODD:  ok = x;
            PARITY_EVEN: ok = ~x;
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; dout presents the head entry while not empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_en;
    logic             push_en;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_en  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign push_en = push & (~full | pop_en);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array; not reset, reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x oversampled UART receiver feeding a show-ahead FIFO with sticky error flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int clk_freq   = 50000000,
    parameter int baud       = 115200,
    parameter int data_bits  = 8,
    parameter int parity     = 0,
    parameter int stop_bits  = 1,
    parameter int fifo_depth = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rd,
    input  logic                          clr_err,
    output logic [data_bits-1:0]          rx_data,
    output logic                          rx_valid,
    output logic [$clog2(fifo_depth):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int              DIV       = baud_div(clk_freq, baud);
    localparam int              TW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0]   DIV_LAST  = TW'(DIV - 1);
    localparam logic [2:0]      LAST_BIT  = 3'(data_bits - 1);
    localparam logic            STOP_LAST = (stop_bits > 1) ? 1'b1 : 1'b0;

    logic                  rx_meta;
    logic                  rx_sync;
    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    rx_state_t             state;
    logic [3:0]            s_cnt;
    logic [2:0]            b_cnt;
    logic                  stop_cnt;
    logic [data_bits-1:0]  shreg;
    logic                  frame_bad;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop_now;
    logic                  drop;

    assign tick     = (tick_cnt == DIV_LAST);
    assign pop_now  = rd & ~fifo_empty;
    assign drop     = push & fifo_full & ~pop_now;
    assign rx_valid = ~fifo_empty;

    // Two-flop synchroniser for the asynchronous line, preset to idle-high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Free-running oversample divider; tick is high on the wrap cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Frame FSM plus sticky flags; later set assignments override clr_err.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            s_cnt      <= 4'd0;
            b_cnt      <= 3'd0;
            stop_cnt   <= 1'b0;
            shreg      <= '0;
            frame_bad  <= 1'b0;
            push       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            push <= 1'b0;
            if (clr_err) begin
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
                overrun    <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (!rx_sync) begin
                            state <= ST_START;
                            s_cnt <= 4'd0;
                        end
                    end
                    ST_START: begin
                        if (s_cnt == SAMPLE_MID) begin
                            s_cnt <= 4'd0;
                            if (!rx_sync) begin
                                state     <= ST_DATA;
                                b_cnt     <= 3'd0;
                                frame_bad <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        if (s_cnt == SAMPLE_END) begin
                            s_cnt <= 4'd0;
                            shreg <= {rx_sync, shreg[data_bits-1:1]};
                            if (b_cnt == LAST_BIT) begin
                                b_cnt    <= 3'd0;
                                stop_cnt <= 1'b0;
                                state    <= (parity != PARITY_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                b_cnt <= b_cnt + 3'd1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                    ST_PARITY: begin
                        if (s_cnt == SAMPLE_END) begin
                            s_cnt <= 4'd0;
                            state <= ST_STOP;
                            if (!parity_ok(^shreg, rx_sync, parity)) begin
                                frame_bad  <= 1'b1;
                                parity_err <= 1'b1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                    ST_STOP: begin
                        if (s_cnt == SAMPLE_END) begin
                            s_cnt <= 4'd0;
                            if (!rx_sync) begin
                                frame_bad <= 1'b1;
                                frame_err <= 1'b1;
                            end
                            if (stop_cnt == STOP_LAST) begin
                                state <= ST_IDLE;
                                push  <= rx_sync & ~frame_bad;
                            end else begin
                                stop_cnt <= stop_cnt + 1'b1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    sync_fifo #(
        .WIDTH (data_bits),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd),
        .din   (shreg),
        .dout  (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
